// File: rtl/nasti_write_engine_pkg.sv
// Shared NASTI write-path types, burst/response encodings and engine state type.
// Both the write engine and the address generator import this package.
package nasti_write_engine_pkg;

  localparam int NASTI_ID_WIDTH   = 4;
  localparam int NASTI_ADDR_WIDTH = 32;
  localparam int NASTI_DATA_WIDTH = 64;
  localparam int NASTI_USER_WIDTH = 2;
  localparam int NASTI_STRB_WIDTH = NASTI_DATA_WIDTH / 8;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [NASTI_ID_WIDTH-1:0]   id;
    logic [NASTI_ADDR_WIDTH-1:0] addr;
    logic [7:0]                  len;
    logic [2:0]                  size;
    logic [1:0]                  burst;
    logic [NASTI_USER_WIDTH-1:0] user;
  } aw_trans;

  typedef struct packed {
    logic [NASTI_DATA_WIDTH-1:0] data;
    logic [NASTI_STRB_WIDTH-1:0] strb;
    logic                        last;
  } w_trans;

  typedef struct packed {
    logic [NASTI_ID_WIDTH-1:0]   id;
    logic [1:0]                  resp;
    logic [NASTI_USER_WIDTH-1:0] user;
  } b_trans;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  // log2(len+1) for the legal WRAP lengths; 0 flags an illegal WRAP length.
  function automatic logic [3:0] wrap_shift(input logic [7:0] len);
    case (len)
      8'd1:    return 4'd1;
      8'd3:    return 4'd2;
      8'd7:    return 4'd3;
      8'd15:   return 4'd4;
      default: return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/nasti_write_engine_addr_gen.sv
// Combinational next-beat byte address for FIXED, INCR and WRAP bursts.
// Kept standalone so the read engine can share the same address rules.
module nasti_addr_gen
  import nasti_write_engine_pkg::*;
#(
  parameter int ADDR_WIDTH = NASTI_ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [2:0]            size,
  input  logic [7:0]            len,
  input  logic [1:0]            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] beat_bytes;
  logic [ADDR_WIDTH-1:0] wrap_bytes;
  logic [ADDR_WIDTH-1:0] incr_next;
  logic [ADDR_WIDTH-1:0] wrap_next;

  // INCR realigns after the first (possibly unaligned) beat; WRAP folds back at the wrap boundary.
  always_comb begin
    beat_bytes = ONE << size;
    wrap_bytes = beat_bytes << wrap_shift(len);
    incr_next  = (addr & ~(beat_bytes - ONE)) + beat_bytes;
    wrap_next  = addr + beat_bytes;
    if ((wrap_next & (wrap_bytes - ONE)) == '0) begin
      wrap_next = wrap_next - wrap_bytes;
    end
    case (burst)
      BURST_INCR: next_addr = incr_next;
      BURST_WRAP: next_addr = wrap_next;
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/nasti_write_engine.sv
// Core-clock NASTI write engine: pops one AW, emits one memory command per W beat,
// then pushes a single B response for the burst.
module nasti_write_engine
  import nasti_write_engine_pkg::*;
#(
  parameter int C_NASTI_ID_WIDTH   = NASTI_ID_WIDTH,
  parameter int C_NASTI_ADDR_WIDTH = NASTI_ADDR_WIDTH,
  parameter int C_NASTI_DATA_WIDTH = NASTI_DATA_WIDTH,
  parameter int C_NASTI_USER_WIDTH = NASTI_USER_WIDTH
) (
  input  logic                            core_clk,
  input  logic                            core_arstn,
  input  aw_trans                         aw_rdata,
  input  logic                            aw_rempty,
  output logic                            aw_rden,
  input  w_trans                          w_rdata,
  input  logic                            w_rempty,
  output logic                            w_rden,
  output b_trans                          b_wdata,
  input  logic                            b_wfull,
  output logic                            b_wren,
  output logic                            cmd_valid,
  input  logic                            cmd_ready,
  output logic [C_NASTI_ADDR_WIDTH-1:0]   cmd_addr,
  output logic [C_NASTI_DATA_WIDTH-1:0]   cmd_data,
  output logic [C_NASTI_DATA_WIDTH/8-1:0] cmd_strb
);

  localparam logic [2:0] SIZE_MAX = 3'($clog2(C_NASTI_DATA_WIDTH / 8));

  state_t                          state;
  state_t                          state_nxt;
  logic [C_NASTI_ID_WIDTH-1:0]     id_q;
  logic [C_NASTI_USER_WIDTH-1:0]   user_q;
  logic [7:0]                      len_q;
  logic [2:0]                      size_q;
  logic [1:0]                      burst_q;
  logic [7:0]                      cnt;
  logic [C_NASTI_ADDR_WIDTH-1:0]   addr;
  logic [C_NASTI_ADDR_WIDTH-1:0]   next_addr;
  logic [C_NASTI_ADDR_WIDTH-1:0]   size_mask;
  logic                            aw_bad;
  logic                            drop_cmds;
  logic                            resp_err;
  logic                            last_beat;

  // An illegal AW is still fully drained, but never reaches the command interface.
  always_comb begin
    size_mask = ~({C_NASTI_ADDR_WIDTH{1'b1}} << aw_rdata.size);
    aw_bad    = 1'b0;
    if (aw_rdata.burst == 2'b11) begin
      aw_bad = 1'b1;
    end
    if (aw_rdata.size > SIZE_MAX) begin
      aw_bad = 1'b1;
    end
    if (aw_rdata.burst == BURST_WRAP &&
        (wrap_shift(aw_rdata.len) == 4'd0 || (aw_rdata.addr & size_mask) != '0)) begin
      aw_bad = 1'b1;
    end
  end

  assign last_beat = (cnt == len_q);

  nasti_addr_gen #(
    .ADDR_WIDTH (C_NASTI_ADDR_WIDTH)
  ) u_addr_gen (
    .addr      (addr),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  always_comb begin
    state_nxt = state;
    aw_rden   = 1'b0;
    w_rden    = 1'b0;
    cmd_valid = 1'b0;
    b_wren    = 1'b0;
    case (state)
      IDLE: begin
        if (!aw_rempty) begin
          aw_rden   = 1'b1;
          state_nxt = DATA;
        end
      end
      DATA: begin
        if (drop_cmds) begin
          w_rden = !w_rempty;
        end else begin
          cmd_valid = !w_rempty;
          w_rden    = !w_rempty && cmd_ready;
        end
        if (w_rden && last_beat) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        b_wren = !b_wfull;
        if (!b_wfull) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Payload outputs are forced to zero whenever they carry no meaning.
  always_comb begin
    cmd_addr = '0;
    cmd_data = '0;
    cmd_strb = '0;
    b_wdata  = '0;
    if (cmd_valid) begin
      cmd_addr = addr;
      cmd_data = w_rdata.data;
      cmd_strb = w_rdata.strb;
    end
    if (state == RESP) begin
      b_wdata.id   = id_q;
      b_wdata.resp = resp_err ? RESP_SLVERR : RESP_OKAY;
      b_wdata.user = user_q;
    end
  end

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      id_q      <= '0;
      user_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      cnt       <= '0;
      addr      <= '0;
      drop_cmds <= 1'b0;
      resp_err  <= 1'b0;
    end else begin
      if (aw_rden) begin
        id_q      <= aw_rdata.id;
        user_q    <= aw_rdata.user;
        len_q     <= aw_rdata.len;
        size_q    <= aw_rdata.size;
        burst_q   <= aw_rdata.burst;
        cnt       <= '0;
        addr      <= aw_rdata.addr;
        drop_cmds <= aw_bad;
        resp_err  <= aw_bad;
      end
      // The beat count, not w_last, decides where the burst ends.
      if (w_rden) begin
        if (w_rdata.last != last_beat) begin
          resp_err <= 1'b1;
        end
        cnt  <= cnt + 8'd1;
        addr <= next_addr;
      end
    end
  end

endmodule
